// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder shift engine: FSM states,
// default frame width and the CPOL/CPHA mode encoding.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DATA_W_DEFAULT = 8;

  // Mode number is {cpol, cpha}, matching the usual SPI mode numbering.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  function automatic logic mode_cpol(input spi_mode_t m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Plain flop-chain synchronizer used on each asynchronous SPI pin.
// RESET_VAL lets each pin reset to its idle level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic pclk,
  input  logic preset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pin value through STAGES flops
  always_ff @(posedge pclk) begin
    if (preset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_shift_reg.sv
// SPI responder-side shift engine running in the pclk domain. The SPI pins
// are oversampled; sclk edges are found by comparing the synced level with
// a one-cycle-delayed copy, and classified as leading or trailing relative
// to the CPOL captured when ss went low.
module spi_slave_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d;

  state_t    state, state_next;
  spi_mode_t mode;
  logic      cpol, cpha, lsbfe;

  logic [DATA_W-1:0] tx_buf, tx_sh, rx_sh, rx_next, rx_data;
  logic              tx_full, byte_done, rx_valid;
  logic [CNT_W-1:0]  bit_cnt;

  logic ss_fall, start, stop, in_xfer;
  logic sclk_edge, leading, trailing, sample_edge, shift_edge;
  logic handshake, sh_load;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .pclk(pclk), .preset(preset), .d(sclk_i), .q(sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .pclk(pclk), .preset(preset), .d(ss_i), .q(ss_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .pclk(pclk), .preset(preset), .d(mosi_i), .q(mosi_s)
  );

  assign cpol = mode_cpol(mode);
  assign cpha = mode_cpha(mode);

  assign ss_fall = ss_d & ~ss_s;
  assign start   = (state == IDLE) & ss_fall;
  assign stop    = (state == ACTIVE) & ss_s;
  assign in_xfer = (state == ACTIVE) & ~ss_s;

  assign sclk_edge = sclk_s ^ sclk_d;
  assign leading   = sclk_edge & (sclk_d == cpol);
  assign trailing  = sclk_edge & (sclk_s == cpol);

  assign sample_edge = in_xfer & (cpha ? trailing : leading);
  assign shift_edge  = in_xfer & (cpha ? leading : trailing);

  // With cpha=0 the first bit must be on miso before any clock edge, so the
  // shifter is loaded at selection; with cpha=1 it waits for the first
  // leading edge of each byte. cpha=0 reloads on the shift edge after a
  // completed byte instead of shifting.
  assign handshake = tx_load_i & ~tx_full;
  assign sh_load   = (start & ~cpha_i)
                   | (shift_edge & (cpha ? (bit_cnt == '0) : byte_done));

  assign rx_next = lsbfe ? {mosi_s, rx_sh[DATA_W-1:1]}
                         : {rx_sh[DATA_W-2:0], mosi_s};

  assign miso_o     = lsbfe ? tx_sh[0] : tx_sh[DATA_W-1];
  assign miso_oe_o  = (state == ACTIVE);
  assign busy_o     = (state == ACTIVE);
  assign tx_ready_o = ~tx_full;
  assign rx_data_o  = rx_data;
  assign rx_valid_o = rx_valid;

  // Delayed copies of synced sclk and ss for edge detection
  always_ff @(posedge pclk) begin
    if (preset) begin
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: select starts a frame, deselect ends it
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  if (ss_s)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Mode is frozen at selection so mid-frame changes cannot corrupt a byte
  always_ff @(posedge pclk) begin
    if (preset) begin
      mode  <= MODE0;
      lsbfe <= 1'b0;
    end else if (start) begin
      mode  <= spi_mode_t'({cpol_i, cpha_i});
      lsbfe <= lsbfe_i;
    end
  end

  // Transmit buffer: a new byte wins over a same-cycle load into the shifter
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (handshake) begin
      tx_buf  <= tx_data_i;
      tx_full <= 1'b1;
    end else if (sh_load) begin
      tx_full <= 1'b0;
    end
  end

  // Transmit shifter: load from the buffer (zeros if empty) or shift out
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_sh <= '0;
    end else if (sh_load) begin
      tx_sh <= tx_full ? tx_buf : '0;
    end else if (shift_edge) begin
      tx_sh <= lsbfe ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
    end
  end

  // Receive shifter, bit counter and completed-byte pulse
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_sh     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start || stop) begin
        rx_sh     <= '0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (sample_edge) begin
        rx_sh <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          byte_done <= 1'b1;
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (sh_load) begin
        byte_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_slave_shift_reg.md
# spi_slave_shift_reg

SPI responder-side shift engine: receives the serial stream driven by the SPI master's shift register (sclk, ss, mosi) and returns data on miso. It runs entirely in the APB `pclk` domain, oversampling the external SPI pins, and supports all four CPOL/CPHA modes plus MSB- or LSB-first framing. It is the far-end partner of the master shift register and serves both as a loop-back target in system simulation and as a slave-mode datapath for the SPI peripheral.

## Interface
- `DATA_W`, 8 — frame width in bits.
- `SYNC_STAGES`, 2 — synchronizer depth on `sclk_i`, `ss_i` and `mosi_i`.

Ports:
- `pclk` input 1 — single clock for all logic.
- `preset` input 1 — synchronous, active-high reset.
- `cpol_i`, `cpha_i`, `lsbfe_i` input 1 each — mode select; captured at the ss assertion.
- `sclk_i` input 1 — SPI clock from the master (asynchronous).
- `ss_i` input 1 — slave select, active low (asynchronous).
- `mosi_i` input 1 — serial data from the master.
- `miso_o` output 1 — serial data to the master.
- `miso_oe_o` output 1 — miso drive enable; 1 only while selected.
- `tx_data_i` input DATA_W — next byte to return to the master.
- `tx_load_i` input 1 — write strobe for `tx_data_i`.
- `tx_ready_o` output 1 — transmit buffer empty; accepts a load.
- `rx_data_o` output DATA_W — last complete received byte.
- `rx_valid_o` output 1 — one-cycle pulse when `rx_data_o` updates.
- `busy_o` output 1 — high in ACTIVE state.

## Operation
- Synchronization and edge detection:
  - `sclk_i`, `ss_i` and `mosi_i` each pass through SYNC_STAGES flops.
  - The synced sclk is registered once more for edge detection.
  - Leading edge = transition away from the captured cpol level; trailing edge = transition back to it.
- Edge roles:
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge.
- States:
  - IDLE → ACTIVE on synced ss falling: capture cpol/cpha/lsbfe, clear `bit_cnt`. If cpha=0, load `tx_sh` from the buffer immediately.
  - ACTIVE → IDLE on synced ss high.
- Transmit buffer:
  - A handshake (`tx_load_i` && `tx_ready_o`) writes `tx_buf` and sets `tx_full`.
  - A load into `tx_sh` clears `tx_full`.
  - If the buffer is empty at a load, `tx_sh` loads 8'h00.
  - A handshake and a load in the same cycle: the load takes the old contents (or 00 if empty), then the buffer takes the new byte.
- Miso output: `miso_o` = lsbfe ? `tx_sh[0]` : `tx_sh[DATA_W-1]`. A shift moves `tx_sh` toward the output bit.
- Sample edge:
  - MSB-first: `rx_sh` <= {`rx_sh[DATA_W-2:0]`, mosi}.
  - LSB-first: `rx_sh` <= {mosi, `rx_sh[DATA_W-1:1]`}.
  - `bit_cnt`++. At `bit_cnt`==DATA_W-1 the counter wraps to 0 and `byte_done` is set.
- Shift edge:
  - cpha=1 with `bit_cnt`==0: load `tx_sh` from the buffer.
  - cpha=0 with `byte_done`: reload `tx_sh` from the buffer instead of shifting, then clear `byte_done`.
  - Otherwise: shift.
- Completed byte: `rx_data_o` <= assembled byte and `rx_valid_o`=1 for exactly one cycle. A new byte overwrites the old one with no overrun flag.
- ss deasserted mid-byte:
  - Partial `rx_sh` is discarded; no `rx_valid_o`.
  - `bit_cnt` and `byte_done` are cleared.
  - `tx_buf`/`tx_full` are untouched; `tx_sh` is retained but unused.
- Mode inputs are ignored while ACTIVE.

## Timing
- Values after `preset`:
  - State IDLE.
  - `miso_o`=0, `miso_oe_o`=0.
  - `tx_ready_o`=1, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0.
  - `tx_buf`, `tx_sh`, `rx_sh`, `bit_cnt` all 0.
- Reset mid-transfer returns to these values on the next `pclk` edge, whatever ss does.
- Pin-to-detection: an sclk edge is acted on SYNC_STAGES+1 `pclk` cycles after the pin changes.
- `rx_valid_o` rises 1 cycle after the final sample edge is detected.
- `miso_o` changes 1 cycle after the shift edge is detected. The first bit is valid SYNC_STAGES+2 cycles after ss falls (cpha=0).
- Constraints: each sclk phase ≥ 4 `pclk` cycles (sclk ≤ pclk/8). ss setup/hold to sclk ≥ 4 `pclk` cycles.

## Structure
- Shared package `spi_pkg`:
  - state enum (IDLE, ACTIVE)
  - DATA_W default
  - mode encoding (cpol/cpha pairs)
- Sub-module `spi_sync`: SYNC_STAGES flop chain, instantiated three times.

## Test plan
- Mode 0, MSB-first, buffer=8'h3C, master sends 8'hA5 → `rx_data_o`=8'hA5, one `rx_valid_o` pulse; miso bits 0,0,1,1,1,1,0,0.
- Mode 3, LSB-first, buffer=8'h81, master sends 8'h0F → `rx_data_o`=8'h0F; miso bits 1,0,0,0,0,0,0,1.
- Mode 1, back-to-back bytes 8'h12, 8'h34 with buffer reloaded after the first load → two `rx_valid_o` pulses; miso returns both buffered bytes; `tx_ready_o` toggles 1→0→1.
- Empty buffer, mode 2 → miso returns 8'h00; `rx_data_o` is still correct.
- ss released after 5 bits, then a full byte 8'hC3 → no pulse for the partial byte, `rx_data_o`=8'hC3 afterwards.
- `preset` asserted mid-byte → all outputs return to their reset values next cycle; a following transfer works normally.
